// File: rtl/xalu_nibble_sequencer_if.sv
// rtl/xalu_nibble_sequencer_if.sv - host request/response bundle for the nibble sequencer
// Host drives the request side; the sequencer returns completion and flags.
interface xalu_nibble_sequencer_if #(
   parameter int NIBBLES = 4
) ();
   localparam int W = 4 * NIBBLES;

   logic         start;
   logic [2:0]   func;
   logic         com;
   logic         cin;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         carry_out;
   logic         zero;
   logic         equal;

   modport master (
      output start, func, com, cin, a, b,
      input  busy, done, result, carry_out, zero, equal
   );

   modport slave (
      input  start, func, com, cin, a, b,
      output busy, done, result, carry_out, zero, equal
   );
endinterface

// File: rtl/xalu_nibble_sequencer.sv
// rtl/xalu_nibble_sequencer.sv - runs word operations through one 4-bit xalu slice, a nibble per clock
// SHR walks MSB-first using the right carry-out; every other function walks LSB-first using the left carry-out.
module xalu_nibble_sequencer #(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   xalu_nibble_sequencer_if.slave   host,
   output logic [3:0]               alu_a,
   output logic [3:0]               alu_b,
   output logic [2:0]               alu_f,
   output logic                     alu_ci_right,
   output logic                     alu_ci_left,
   output logic                     alu_com,
   input  logic [3:0]               alu_d,
   input  logic                     alu_co_left,
   input  logic                     alu_co_right,
   input  logic                     alu_equ
);
   localparam int W  = 4 * NIBBLES;
   localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);
   localparam logic [2:0]    F_SHR    = 3'd6;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [2:0]    func_q, func_d;
   logic          com_q, com_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] cnt_q, cnt_d;
   logic          chain_q, chain_d;
   logic          eq_acc_q, eq_acc_d;
   logic [W-1:0]  work_q, work_d;
   logic [W-1:0]  result_q, result_d;
   logic          carry_q, carry_d;
   logic          zero_q, zero_d;
   logic          equal_q, equal_d;

   logic          is_shr;
   logic          accept;
   logic [W-1:0]  work_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         func_q   <= '0;
         com_q    <= 1'b0;
         idx_q    <= '0;
         cnt_q    <= '0;
         chain_q  <= 1'b0;
         eq_acc_q <= 1'b0;
         work_q   <= '0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         equal_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         func_q   <= func_d;
         com_q    <= com_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         chain_q  <= chain_d;
         eq_acc_q <= eq_acc_d;
         work_q   <= work_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         equal_q  <= equal_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      a_d          = a_q;
      b_d          = b_q;
      func_d       = func_q;
      com_d        = com_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      chain_d      = chain_q;
      eq_acc_d     = eq_acc_q;
      work_d       = work_q;
      result_d     = result_q;
      carry_d      = carry_q;
      zero_d       = zero_q;
      equal_d      = equal_q;
      work_next    = work_q;
      accept       = 1'b0;
      is_shr       = (func_q == F_SHR);

      alu_a        = 4'd0;
      alu_b        = 4'd0;
      alu_f        = func_q;
      alu_ci_right = 1'b0;
      alu_ci_left  = 1'b0;
      alu_com      = 1'b0;

      case (state_q)
         S_IDLE: begin
            accept = host.start;
         end
         S_RUN: begin
            alu_a        = a_q[{idx_q, 2'b00} +: 4];
            alu_b        = b_q[{idx_q, 2'b00} +: 4];
            alu_com      = com_q;
            alu_ci_right = is_shr ? 1'b0 : chain_q;
            alu_ci_left  = is_shr ? chain_q : 1'b0;

            work_next[{idx_q, 2'b00} +: 4] = alu_d;
            work_d   = work_next;
            eq_acc_d = eq_acc_q & alu_equ;
            chain_d  = is_shr ? alu_co_right : alu_co_left;
            idx_d    = is_shr ? (idx_q - 1'b1) : (idx_q + 1'b1);
            cnt_d    = cnt_q + 1'b1;

            // Publish the whole word and its flags in one step so they appear together.
            if (cnt_q == LAST_IDX) begin
               state_d  = S_DONE;
               result_d = work_next;
               carry_d  = chain_d;
               zero_d   = (work_next == '0);
               equal_d  = eq_acc_d;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            accept  = host.start;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (accept) begin
         state_d  = S_RUN;
         a_d      = host.a;
         b_d      = host.b;
         func_d   = host.func;
         com_d    = host.com;
         idx_d    = (host.func == F_SHR) ? LAST_IDX : '0;
         cnt_d    = '0;
         chain_d  = host.cin;
         eq_acc_d = 1'b1;
      end
   end

   assign host.busy      = (state_q == S_RUN);
   assign host.done      = (state_q == S_DONE);
   assign host.result    = result_q;
   assign host.carry_out = carry_q;
   assign host.zero      = zero_q;
   assign host.equal     = equal_q;
endmodule
